id_decode_stage: RTL

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

---
 rtl/id_decode_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/id_decode_stage.sv
// Instruction-decode pipeline register with load-use hazard stall and immediate-type decode.
// Optional stall-cycle counter enabled by defining ID_STALL_CNT_EN.
module id_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [24:0] imm_field,
    output logic [2:0]  imm_sel,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_NONE = 3'b111
    } imm_type_e;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [6:0]  opcode;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        legal;
    logic        hazard;
    logic        hold;

    assign opcode = instr_q[6:0];

    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        legal    = 1'b1;
        imm_sel  = IMM_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm_sel = IMM_I;
            OP_STORE: begin
                imm_sel  = IMM_S;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                imm_sel  = IMM_B;
                uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_sel  = IMM_U;
                uses_rs1 = 1'b0;
            end
            OP_JAL: begin
                imm_sel  = IMM_J;
                uses_rs1 = 1'b0;
            end
            OP_REG: uses_rs2 = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign rd        = instr_q[11:7];
    assign imm_field = instr_q[31:7];
    assign id_pc     = pc_q;
    assign id_instr  = instr_q;

    assign hazard   = valid_q & ex_mem_read & (ex_rd != 5'd0) &
                      ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
    assign hold     = hazard | (valid_q & ~ex_ready);
    assign id_ready = ~hold;
    assign id_valid = valid_q & ~hazard;
    assign illegal  = valid_q & ~legal;

    // Flush only kills the valid bit; pc/instr stay so decode outputs remain stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= 32'h0000_0013;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (id_ready) begin
            valid_q <= if_valid;
            pc_q    <= if_pc;
            instr_q <= if_instr;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (valid_q & hold & ~flush) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule
